// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and datapath widths.
package program_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_CHECK,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_t;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int COUNT_W = 16;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] val);
    return acc + val;
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words and keeps the running mod-256 checksum.
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_complete,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] checksum
);

  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] assembly;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= '0;
      assembly <= '0;
      checksum <= '0;
    end else if (accept) begin
      assembly[{byte_idx, 3'b000} +: BYTE_W] <= byte_data;
      byte_idx <= byte_idx + 2'd1;
      checksum <= csum_add(checksum, byte_data);
    end
  end

  // The top byte is merged combinationally so the word is ready on the accepting edge.
  assign word_complete = accept && (byte_idx == 2'd3);
  assign word          = {byte_data, assembly[23:0]};

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: fills instruction memory, verifies checksum, releases CPU reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          PROGRAM_SIZE = 29,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               byte_ready,
  output logic               imem_wr_en,
  output logic [WORD_W-1:0]  imem_wr_addr,
  output logic [WORD_W-1:0]  imem_wr_data,
  output logic               cpu_reset_n,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] word_count
);

  localparam logic [COUNT_W-1:0] LAST_WORD = COUNT_W'(PROGRAM_SIZE - 1);

  ldr_state_t        state_q, state_d;
  logic              accept, load_accept, start_ok;
  logic              word_complete;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] checksum;

  assign accept      = byte_valid && byte_ready;
  assign load_accept = accept && (state_q == LDR_LOAD);
  assign start_ok    = start && (state_q == LDR_IDLE || state_q == LDR_DONE ||
                                 state_q == LDR_ERROR);

  program_loader_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .accept       (load_accept),
    .byte_data    (byte_data),
    .word_complete(word_complete),
    .word         (word),
    .checksum     (checksum)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= LDR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: if (start) state_d = LDR_LOAD;
      LDR_LOAD:  if (word_complete && word_count == LAST_WORD) state_d = LDR_CHECK;
      LDR_CHECK: if (accept) state_d = (byte_data == checksum) ? LDR_DONE : LDR_ERROR;
      default:   state_d = LDR_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_reset_n  <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      word_count   <= '0;
    end else begin
      byte_ready  <= (state_d == LDR_LOAD) || (state_d == LDR_CHECK);
      busy        <= (state_d == LDR_LOAD) || (state_d == LDR_CHECK);
      done        <= (state_d == LDR_DONE);
      error       <= (state_d == LDR_ERROR);
      cpu_reset_n <= (state_d == LDR_DONE);
      imem_wr_en  <= word_complete;
      if (start_ok) begin
        word_count <= '0;
      end else if (word_complete) begin
        imem_wr_addr <= BASE_ADDR + {14'b0, word_count, 2'b00};
        imem_wr_data <= word;
        word_count   <= word_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; two instances differ only in BASE_ADDR.
module tb_program_loader;

  localparam int          PS     = 2;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        ready_a, wr_en_a, cpu_rn_a, busy_a, done_a, error_a;
  logic [31:0] wr_addr_a, wr_data_a;
  logic [15:0] wc_a;
  logic        ready_b, wr_en_b, cpu_rn_b, busy_b, done_b, error_b;
  logic [31:0] wr_addr_b, wr_data_b;
  logic [15:0] wc_b;

  always #5 clk = ~clk;

  program_loader #(.PROGRAM_SIZE(PS), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_a), .imem_wr_en(wr_en_a), .imem_wr_addr(wr_addr_a),
    .imem_wr_data(wr_data_a), .cpu_reset_n(cpu_rn_a), .busy(busy_a), .done(done_a),
    .error(error_a), .word_count(wc_a));

  program_loader #(.PROGRAM_SIZE(PS), .BASE_ADDR(BASE_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_b), .imem_wr_en(wr_en_b), .imem_wr_addr(wr_addr_b),
    .imem_wr_data(wr_data_b), .cpu_reset_n(cpu_rn_b), .busy(busy_b), .done(done_b),
    .error(error_b), .word_count(wc_b));

  typedef struct { logic [31:0] off; logic [31:0] data; } wr_t;
  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [PS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected word, on both instances.
  always @(negedge clk) begin
    if (wr_en_a || wr_en_b) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", wr_addr_a, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_en_a", {31'b0, wr_en_a}, 32'd1);
        chk("wr_en_b", {31'b0, wr_en_b}, 32'd1);
        chk("wr_addr_a", wr_addr_a, e.off);
        chk("wr_addr_b", wr_addr_b, BASE_B + e.off);
        chk("wr_data_a", wr_data_a, e.data);
        chk("wr_data_b", wr_data_b, e.data);
      end
    end
  end

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int budget = 200;
    if (rnd) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ready_a && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_final(input bit good);
    chk("done",        {31'b0, done_a},   {31'b0, good});
    chk("error",       {31'b0, error_a},  {31'b0, !good});
    chk("cpu_reset_n", {31'b0, cpu_rn_a}, {31'b0, good});
    chk("busy",        {31'b0, busy_a},   32'd0);
    chk("byte_ready",  {31'b0, ready_a},  32'd0);
    chk("word_count",  {16'b0, wc_a},     PS);
    chk("done_b",      {31'b0, done_b},   {31'b0, good});
    chk("sb_empty",    sb.size(),         32'd0);
  endtask

  task automatic do_load(input bit good, input bit rnd, input int start_at, input bit do_start);
    logic [7:0] sum = 8'h00;
    logic [31:0] w;
    for (int i = 0; i < PS; i++) begin
      sb.push_back('{off: 32'(4 * i), data: prog[i]});
      w = prog[i];
      sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    if (do_start) pulse_start();
    for (int i = 0; i < PS * 4; i++) begin
      w = prog[i / 4];
      send_byte(w[8 * (i % 4) +: 8], rnd);
      if (i + 1 == start_at) pulse_start();
    end
    send_byte(good ? sum : sum + 8'd1, rnd);
    check_final(good);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", {31'b0, ready_a},  32'd0);
    chk("rst_wr_en",      {31'b0, wr_en_a},  32'd0);
    chk("rst_wr_addr",    wr_addr_a,         32'd0);
    chk("rst_wr_data",    wr_data_a,         32'd0);
    chk("rst_cpu_reset_n",{31'b0, cpu_rn_a}, 32'd0);
    chk("rst_busy",       {31'b0, busy_a},   32'd0);
    chk("rst_done",       {31'b0, done_a},   32'd0);
    chk("rst_error",      {31'b0, error_a},  32'd0);
    chk("rst_word_count", {16'b0, wc_a},     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal load, then bad checksum, then recovery from ERROR.
    prog[0] = 32'h00A0_0513; prog[1] = 32'h0000_0073;
    do_load(1'b1, 1'b0, -1, 1'b1);
    do_load(1'b0, 1'b0, -1, 1'b1);
    do_load(1'b1, 1'b0, -1, 1'b1);

    // Bytes offered in IDLE are not consumed; then load with random gaps.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h13;
    for (int i = 0; i < 4; i++) begin
      chk("idle_byte_ready", {31'b0, ready_a}, 32'd0);
      @(negedge clk);
    end
    do_load(1'b1, 1'b1, -1, 1'b1);

    // start during LOAD is ignored.
    do_load(1'b1, 1'b0, 3, 1'b1);

    // Reload from DONE: cpu_reset_n falls as busy rises.
    pulse_start();
    chk("reload_cpu_reset_n", {31'b0, cpu_rn_a}, 32'd0);
    chk("reload_busy",        {31'b0, busy_a},   32'd1);
    chk("reload_done",        {31'b0, done_b},   32'd0);
    chk("reload_word_count",  {16'b0, wc_b},     32'd0);
    do_load(1'b1, 1'b0, -1, 1'b0);

    // Reset after five accepted bytes: only the first word is written.
    sb.push_back('{off: 32'd0, data: prog[0]});
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(i < 4 ? prog[0][8 * i +: 8] : prog[1][7:0], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_byte_ready", {31'b0, ready_a},  32'd0);
    chk("mid_wr_en",      {31'b0, wr_en_a},  32'd0);
    chk("mid_wr_addr",    wr_addr_a,         32'd0);
    chk("mid_wr_data",    wr_data_a,         32'd0);
    chk("mid_cpu_reset_n",{31'b0, cpu_rn_a}, 32'd0);
    chk("mid_busy",       {31'b0, busy_a},   32'd0);
    chk("mid_error",      {31'b0, error_a},  32'd0);
    chk("mid_word_count", {16'b0, wc_a},     32'd0);
    chk("mid_sb_empty",   sb.size(),         32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Random programs, random checksum validity, random gaps.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < PS; i++) prog[i] = $urandom;
      do_load(1'($urandom_range(0, 1)), 1'b1, -1, 1'b1);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface that the cpu reads through rom_addr/instruction.
- Accepts a byte stream (valid/ready), packs little-endian bytes into 32-bit instruction words, and writes them into instruction memory.
- Verifies a trailing 8-bit checksum and releases the CPU from reset only on a clean load.
- Sits between a host link (UART receiver / bench) and the rom write port.

Parameters:
PROGRAM_SIZE, 29, number of 32-bit words per load (1..65535)
BASE_ADDR, 32'h0000_0000, byte address of the first word written

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a load (honoured in IDLE, DONE, ERROR only)
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  incoming program byte
byte_ready  output  1  loader accepts a byte this cycle
imem_wr_en  output  1  instruction-memory write strobe, one cycle per word
imem_wr_addr  output  32  byte address of the word being written
imem_wr_data  output  32  assembled instruction word
cpu_reset_n  output  1  active-low reset to the cpu; 1 only in DONE
busy  output  1  high in LOAD and CHECK
done  output  1  load finished with a good checksum
error  output  1  checksum mismatch
word_count  output  16  words written in the current load

Behaviour:
- Reset: registered synchronously on clk when reset=1. State goes to IDLE.
- Reset values: byte_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_reset_n=0, busy=0, done=0, error=0, word_count=0.
- Byte transfer: occurs on a rising edge where byte_valid && byte_ready. byte_ready is a registered function of state only and is 1 in LOAD and CHECK.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE:
  - All outputs at reset values.
  - start -> LOAD; clears byte_idx (2 bits), word_count, checksum accumulator (8 bits).
- LOAD:
  - Each accepted byte is placed at bits [8*byte_idx+7 : 8*byte_idx]. byte_idx increments and wraps 3->0. The byte is added mod 256 to the checksum.
  - On acceptance of byte_idx=3, the next cycle shows:
    - imem_wr_en=1 for exactly one cycle;
    - imem_wr_data = assembled word;
    - imem_wr_addr = BASE_ADDR + 4*word_count (pre-increment value);
    - word_count then increments.
  - byte_ready stays 1 during the write cycle. The next word's bytes may be accepted back-to-back with no stall.
  - When the accepted byte completes word PROGRAM_SIZE-1 -> CHECK. That word's write strobe still occurs in the first CHECK cycle.
  - start is ignored.
- CHECK:
  - Accepts exactly one byte.
  - Byte equals the accumulator -> DONE; otherwise -> ERROR.
  - start is ignored.
- DONE:
  - byte_ready=0, done=1, cpu_reset_n=1, busy=0. word_count holds PROGRAM_SIZE.
  - start -> LOAD: cpu_reset_n and done drop to 0 in the cycle LOAD is entered; counters clear.
- ERROR:
  - error=1, cpu_reset_n=0, byte_ready=0.
  - start -> LOAD with counters cleared; error drops.
- Bytes offered while byte_ready=0 are not consumed; the producer must hold them.
- Reset mid-load:
  - Returns to IDLE immediately; any partial word is discarded.
  - Words already written remain in memory.
  - cpu_reset_n stays 0.
- start and reset in the same cycle: reset wins.
- Widths:
  - Address arithmetic is 32-bit, wrapping modulo 2^32.
  - word_count is 16-bit; PROGRAM_SIZE must not exceed 65535.

Decomposition:
- State encodings (LDR_IDLE..LDR_ERROR) go as localparams in the shared parameters.vh alongside the existing cpu constants.
- One sub-module is natural: loader_word_packer.
  - Owns: byte_idx, shift/assembly register, checksum accumulator.
  - Outputs: a word_complete pulse.
- The top holds the FSM, address/word counters and output registers.

Test Plan:
- Nominal load, PROGRAM_SIZE=2, BASE_ADDR=0:
  - Stimulus: start, then bytes 13 05 A0 00 73 00 00 00, checksum 2B.
  - Response: writes 0x00A00513 @0x0 and 0x00000073 @0x4, each a 1-cycle strobe; then done=1, cpu_reset_n=1, word_count=2.
- Bad checksum:
  - Stimulus: same bytes with checksum 2C.
  - Response: both writes occur, then error=1, cpu_reset_n=0, done=0. A following start plus a correct stream reaches DONE.
- Backpressure and gaps:
  - Stimulus: byte_valid toggled 1/0 randomly, and bytes offered in IDLE before start.
  - Response: identical writes to the nominal case; pre-start bytes are not consumed (byte_ready=0).
- Reset mid-load:
  - Stimulus: reset asserted after 5 accepted bytes.
  - Response: exactly one write (0x00A00513 @0x0); the next cycle shows all outputs at reset values and state IDLE.
- start during LOAD:
  - Stimulus: start pulsed after 3 bytes.
  - Response: ignored; the load completes normally with word_count=2.
- Reload from DONE with BASE_ADDR=0x100:
  - Stimulus: start while in DONE.
  - Response: cpu_reset_n falls in the same cycle busy rises; first write goes to 0x100.
